cla_sub_pipe: RTL and testbench

//   Pipelined two-stage carry-lookahead subtractor. Computes a - b - b_in as
//   a + ~b + ~b_in, using per-bit p/g terms and GROUP-bit lookahead blocks.

---
 rtl/cla_sub_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_cla_sub_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_pipe.sv
// Purpose : two-stage pipelined carry-lookahead subtractor, diff = a - b - b_in
//           computed as a + ~b + ~b_in, plus unsigned borrow-out and signed overflow.
// Latency : result valid 2 cycles after acceptance; one op per cycle sustained.
// Backpr. : out_ready low freezes the output register; stage 1 holds its operand,
//           and in_ready drops once both stages are full (at most 2 ops in flight).
// Ports   : clk/rst (async active-high); in_valid/in_ready + a, b, b_in on the
//           input side; out_valid/out_ready + diff, b_out, ovf on the output side.
module cla_sub_pipe #(
  parameter int WIDTH = 16,  // operand width, multiple of GROUP
  parameter int GROUP = 4    // lookahead group size
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  // ------------------------------------------------------------------
  // Flow control
  // ------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic in_acc;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_gp_q, s1_gp_d;
  logic [NG-1:0]    s1_gg_q, s1_gg_d;
  logic             s1_c0_q, s1_c0_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_b_msb_q, s1_b_msb_d;

  // Stage 2 (output) state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] new_p;
  logic [WIDTH-1:0] new_g;
  logic [NG-1:0]    new_gp;
  logic [NG-1:0]    new_gg;

  // Stage 2 combinational terms
  logic [NG:0]      gc;        // carry into each group; gc[NG] is the final carry-out
  logic             la_run_p;  // running product of group P in the lookahead expansion
  logic             la_term;   // accumulated generate terms for one group carry
  logic [WIDTH-1:0] bit_c;     // carry into each bit
  logic             c_run;
  logic [WIDTH-1:0] sum;
  logic             ovf_calc;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  // Depends on out_ready combinationally so a full pipe can accept while draining.
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_acc   = in_valid && in_ready;

  // ------------------------------------------------------------------
  // Stage 1: per-bit propagate/generate of a + ~b, then group P/G
  // ------------------------------------------------------------------
  always_comb begin
    new_p  = a ^ ~b;
    new_g  = a & ~b;
    new_gp = '0;
    new_gg = '0;
    for (int k = 0; k < NG; k++) begin
      new_gp[k] = 1'b1;
      new_gg[k] = 1'b0;
      // Walk the group LSB to MSB: G accumulates as g | p & G_lower.
      for (int i = 0; i < GROUP; i++) begin
        new_gg[k] = new_g[k*GROUP+i] | (new_p[k*GROUP+i] & new_gg[k]);
        new_gp[k] = new_gp[k] & new_p[k*GROUP+i];
      end
    end
  end

  always_comb begin
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_gp_d    = s1_gp_q;
    s1_gg_d    = s1_gg_q;
    s1_c0_d    = s1_c0_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    s1_valid_d = s1_valid_q;
    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_p_d     = new_p;
      s1_g_d     = new_g;
      s1_gp_d    = new_gp;
      s1_gg_d    = new_gg;
      s1_c0_d    = ~b_in;  // subtracting the borrow = adding its complement
      s1_a_msb_d = a[WIDTH-1];
      s1_b_msb_d = b[WIDTH-1];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: group carries by full lookahead expansion, then intra-group
  // ------------------------------------------------------------------
  always_comb begin
    gc       = '0;
    la_run_p = 1'b1;
    la_term  = 1'b0;
    gc[0]    = s1_c0_q;
    // carry into group k+1 = OR_j ( G[j] & P[k..j+1] ) | ( P[k..0] & c0 ),
    // so every group carry depends only on stage-1 registers, not on a ripple.
    for (int k = 0; k < NG; k++) begin
      la_run_p = 1'b1;
      la_term  = 1'b0;
      for (int j = k; j >= 0; j--) begin
        la_term  = la_term | (s1_gg_q[j] & la_run_p);
        la_run_p = la_run_p & s1_gp_q[j];
      end
      gc[k+1] = la_term | (la_run_p & s1_c0_q);
    end
  end

  always_comb begin
    bit_c = '0;
    c_run = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c_run = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        bit_c[k*GROUP+i] = c_run;
        c_run = s1_g_q[k*GROUP+i] | (s1_p_q[k*GROUP+i] & c_run);
      end
    end
  end

  assign sum = s1_p_q ^ bit_c;
  // Overflow only possible when operand signs differ; it shows as the
  // result sign disagreeing with the minuend sign.
  assign ovf_calc = (s1_a_msb_q != s1_b_msb_q) && (sum[WIDTH-1] != s1_a_msb_q);

  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    b_out_d     = b_out_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      diff_d  = sum;
      b_out_d = ~gc[NG];  // no carry out of a + ~b + ~b_in means a borrow
      ovf_d   = ovf_calc;
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_gp_q    <= '0;
      s1_gg_q    <= '0;
      s1_c0_q    <= 1'b0;
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_gp_q    <= s1_gp_d;
      s1_gg_q    <= s1_gg_d;
      s1_c0_q    <= s1_c0_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
module tb_cla_sub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;

  cla_sub_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          t;
  } exp_t;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vbi;
    logic [15:0] ed;
    logic        ebo;
    logic        eov;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];

  // values observed in the most recent cycle
  logic        obs_ov, obs_ir, obs_bo, obs_ovf, obs_acc, obs_xfer;
  logic [15:0] obs_diff;
  logic        prev_stall;
  logic [15:0] prev_diff;
  logic        prev_bo, prev_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    exp_t e;
    int ua, ub, ib, r, sa, sb, rs;
    ua = x;
    ub = y;
    ib = bi;
    r  = ua - ub - ib;
    e.d  = r[15:0];
    e.bo = (ua < ub + ib);
    sa = $signed(x);
    sb = $signed(y);
    rs = sa - sb - ib;
    e.ov = (rs > 32767) || (rs < -32768);
    e.t  = cyc;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle, entered and left at the falling edge. Drives inputs,
  // checks the handshake/occupancy/ordering against the scoreboard, then
  // lets the rising edge happen.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ibi, input logic ordy);
    exp_t e;
    logic exp_ov;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    b_in      = ibi;
    out_ready = ordy;
    #1;
    obs_ov   = out_valid;
    obs_ir   = in_ready;
    obs_diff = diff;
    obs_bo   = b_out;
    obs_ovf  = ovf;
    obs_acc  = in_valid && in_ready;
    obs_xfer = out_valid && out_ready;

    // At most two ops in flight; a full pipe can still accept while draining.
    chk("in_ready", {31'b0, in_ready}, {31'b0, (sbq.size() < 2) || ordy});
    // The oldest op is presented exactly two cycles after its acceptance, or later if stalled.
    exp_ov = (sbq.size() > 0) && (sbq[0].t + 2 <= cyc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (prev_stall) begin
      chk("stall_diff_hold", {16'b0, diff}, {16'b0, prev_diff});
      chk("stall_flags_hold", {30'b0, b_out, ovf}, {30'b0, prev_bo, prev_ovf});
    end
    if (obs_xfer) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_diff", {16'b0, diff}, {16'b0, e.d});
        chk("sb_b_out", {31'b0, b_out}, {31'b0, e.bo});
        chk("sb_ovf", {31'b0, ovf}, {31'b0, e.ov});
      end
    end
    if (obs_acc) sbq.push_back(model(ia, ib, ibi));
    prev_stall = out_valid && !out_ready;
    prev_diff  = diff;
    prev_bo    = b_out;
    prev_ovf   = ovf;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, ordy);
  endtask

  vec_t vecs[7];
  int   n_xfer;
  int   guard;
  logic beat3_pending;
  logic [15:0] held_diff;

  initial begin
    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};

    prev_stall = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    b_in = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_outputs", {14'b0, diff, b_out, ovf}, 32'd0);
    rst = 1'b0;

    // ---- directed vectors, one at a time, checking exact latency ----
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vecs[i].va, vecs[i].vb, vecs[i].vbi, 1'b1);
      chk("vec_accept", {31'b0, obs_ir}, 32'd1);
      idle(1'b1);
      chk("vec_not_early", {31'b0, obs_ov}, 32'd0);
      idle(1'b1);
      chk("vec_valid_at_2", {31'b0, obs_ov}, 32'd1);
      chk("vec_diff", {16'b0, obs_diff}, {16'b0, vecs[i].ed});
      chk("vec_b_out", {31'b0, obs_bo}, {31'b0, vecs[i].ebo});
      chk("vec_ovf", {31'b0, obs_ovf}, {31'b0, vecs[i].eov});
      idle(1'b1);
      chk("vec_drop_after", {31'b0, obs_ov}, 32'd0);
    end

    // ---- stall: 3 beats offered with out_ready low ----
    cycle(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0);
    chk("stall_acc1", {31'b0, obs_acc}, 32'd1);
    cycle(1'b1, 16'h0200, 16'h0002, 1'b0, 1'b0);
    chk("stall_acc2", {31'b0, obs_acc}, 32'd1);
    cycle(1'b1, 16'h0300, 16'h0003, 1'b1, 1'b0);
    chk("stall_full_in_ready", {31'b0, obs_ir}, 32'd0);
    held_diff = obs_diff;
    chk("stall_front_diff", {16'b0, held_diff}, 32'h00FF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h0300, 16'h0003, 1'b1, 1'b0);
      chk("stall_blocked", {31'b0, obs_acc}, 32'd0);
      chk("stall_stable", {16'b0, obs_diff}, {16'b0, held_diff});
    end
    beat3_pending = 1'b1;
    n_xfer = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(beat3_pending, 16'h0300, 16'h0003, 1'b1, 1'b1);
      if (obs_acc) beat3_pending = 1'b0;
      if (obs_xfer) n_xfer++;
    end
    chk("release_three_back_to_back", n_xfer, 32'd3);
    chk("release_beat3_taken", {31'b0, beat3_pending}, 32'd0);
    idle(1'b1);
    chk("release_drained", {31'b0, obs_ov}, 32'd0);

    // ---- reset with two ops in flight ----
    cycle(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b1);
    cycle(1'b1, 16'h5555, 16'h1111, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_outputs", {14'b0, diff, b_out, ovf}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    sbq.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (obs_ov) n_xfer++;
    end
    chk("no_stale_after_rst", n_xfer, 32'd0);
    cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1);
    idle(1'b1);
    chk("post_rst_not_early", {31'b0, obs_ov}, 32'd0);
    idle(1'b1);
    chk("post_rst_valid", {31'b0, obs_ov}, 32'd1);
    chk("post_rst_diff", {16'b0, obs_diff}, 32'h0002);

    // ---- random traffic against the scoreboard ----
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd16(), rnd16(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
    end
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      idle(1'b1);
      guard++;
    end
    chk("final_drain_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
